// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Loads the IO-tile configuration flip-flop chain. Bitstream words arrive on
// a valid/ready stream and are serialised LSB first onto ccff_head, with
// ccff_shift_en qualifying the external chain clock gate. Exactly CHAIN_LEN
// bits are shifted per pass; surplus bits in the final word are dropped.
// An optional verify pass re-shifts the same stream while comparing the bit
// leaving the chain tail with the bit being driven into the head.
//
// Ports
//   prog_clk       programming clock, all state on the rising edge
//   prog_reset     asynchronous active-high reset
//   start          pulse, begins a load (accepted only in IDLE or DONE)
//   verify_en      sampled with start: follow the load with a verify pass
//   abort          pulse, return to IDLE from any state (beats start/shift)
//   word_data      bitstream word, consumed LSB first
//   word_valid     word_data is valid
//   word_ready     word accepted on valid & ready
//   ccff_head      registered serial bit into the chain head
//   ccff_shift_en  registered chain advance enable, aligned with ccff_head
//   ccff_tail      serial bit out of the chain tail
//   busy           high in LOAD or VERIFY
//   done           one-cycle pulse when the final pass completes
//   verify_fail    sticky mismatch flag, cleared on an accepted start
//   mismatch_cnt   mismatches seen in the last verify pass, saturating
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 40,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_fail,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  // Bits still waiting in the word register after the one shifted at accept.
  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q;
  logic [WB_W-1:0]   bits_rem_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              verify_lat_q;
  logic              head_q;
  logic              shift_en_q;
  logic              done_q;
  logic              verify_fail_q;
  logic [CNT_W-1:0]  mismatch_q;

  // Combinational control
  logic              in_pass;
  logic              pass_full;
  logic              ready_c;
  logic              accept;
  logic              shift_from_reg;
  logic              do_shift;
  logic              next_bit;
  logic              start_acc;
  logic              mismatch;
  logic [WB_W-1:0]   take_m1;
  int                chain_left;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    in_pass        = (state_q == LOAD) || (state_q == VERIFY);
    pass_full      = (bit_cnt_q == CNT_W'(CHAIN_LEN));
    start_acc      = 1'b0;
    take_m1        = '0;
    chain_left     = CHAIN_LEN - int'(bit_cnt_q);

    // The word register counts as empty once its last bit has been driven;
    // the next word is then taken and its LSB driven in the same edge, which
    // keeps the chain advancing every cycle while words keep coming.
    ready_c        = in_pass && (bits_rem_q == '0) && !pass_full && !abort;
    accept         = ready_c && word_valid;
    shift_from_reg = in_pass && (bits_rem_q != '0) && !abort;
    do_shift       = shift_from_reg || accept;
    next_bit       = shift_from_reg ? word_q[0] : word_data[0];

    // A word never contributes more bits than the chain still needs, so the
    // tail of an oversized final word is never shifted.
    if (chain_left >= WORD_W) begin
      take_m1 = WB_W'(WORD_W - 1);
    end else begin
      take_m1 = WB_W'(chain_left - 1);
    end

    // The chain tail is only meaningful on cycles where the chain advances.
    mismatch = (state_q == VERIFY) && shift_en_q && !abort &&
               (ccff_tail != head_q);

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = LOAD;
            start_acc = 1'b1;
          end
        end
        // pass_full means the last bit is on ccff_head this cycle; leaving
        // now puts done one cycle after the final shift.
        LOAD: begin
          if (pass_full) begin
            state_d = verify_lat_q ? VERIFY : DONE;
          end
        end
        VERIFY: begin
          if (pass_full) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      word_q        <= '0;
      bits_rem_q    <= '0;
      bit_cnt_q     <= '0;
      verify_lat_q  <= 1'b0;
      head_q        <= 1'b0;
      shift_en_q    <= 1'b0;
      done_q        <= 1'b0;
      verify_fail_q <= 1'b0;
      mismatch_q    <= '0;
    end else begin
      shift_en_q <= do_shift;
      done_q     <= (state_d == DONE) && (state_q != DONE);

      // ccff_head only changes on a real shift, so it holds through stalls.
      if (do_shift) begin
        head_q <= next_bit;
      end

      if (abort) begin
        word_q     <= '0;
        bits_rem_q <= '0;
      end else if (shift_from_reg) begin
        word_q     <= word_q >> 1;
        bits_rem_q <= bits_rem_q - WB_W'(1);
      end else if (accept) begin
        word_q     <= word_data >> 1;
        bits_rem_q <= take_m1;
      end

      // Both passes count chain positions from zero so that position k of
      // the verify pass lines up with position k of the load pass.
      if (start_acc || (state_q == LOAD && state_d == VERIFY)) begin
        bit_cnt_q <= '0;
      end else if (do_shift) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end

      if (start_acc) begin
        verify_lat_q  <= verify_en;
        verify_fail_q <= 1'b0;
        mismatch_q    <= '0;
      end else if (mismatch) begin
        verify_fail_q <= 1'b1;
        if (mismatch_q != CNT_W'(CHAIN_LEN)) begin
          mismatch_q <= mismatch_q + CNT_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign word_ready    = ready_c;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = in_pass;
  assign done          = done_q;
  assign verify_fail   = verify_fail_q;
  assign mismatch_cnt  = mismatch_q;

endmodule
